// File: rtl/serial_rx8.sv
// serial_rx8: frame receiver (start 0, DATA_W data bits LSB first, optional even parity, stop 1).
// Define PARITY_EN to add the parity slot and par_err reporting; default build has no parity.
module serial_rx8 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              sin,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frm_err,
    output logic              par_err,
    output logic              busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for a start bit
    // DATA   | shifting data bits in, LSB first
    // PARITY | sampling the parity bit (PARITY_EN builds only)
    // STOP   | sampling the stop bit, then reporting the frame result
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shr;
    logic [3:0]        cnt;

`ifdef PARITY_EN
    logic par_bit;
    logic par_ok;

    // Even parity: data bits and parity bit together must XOR to zero.
    assign par_ok = ~((^shr) ^ par_bit);
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shr     <= '0;
            cnt     <= '0;
            data    <= '0;
            valid   <= 1'b0;
            frm_err <= 1'b0;
            busy    <= 1'b0;
`ifdef PARITY_EN
            par_bit <= 1'b0;
            par_err <= 1'b0;
`endif
        end else begin
            valid   <= 1'b0;
            frm_err <= 1'b0;
`ifdef PARITY_EN
            par_err <= 1'b0;
`endif
            if (bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (!sin) begin
                            state <= DATA;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shr <= {sin, shr[DATA_W-1:1]};
                        cnt <= cnt + 4'd1;
                        if (cnt == LAST_BIT) begin
`ifdef PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef PARITY_EN
                    PARITY: begin
                        par_bit <= sin;
                        state   <= STOP;
                    end
`endif
                    STOP: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        frm_err <= ~sin;
`ifdef PARITY_EN
                        par_err <= ~par_ok;
                        if (sin && par_ok) begin
                            data  <= shr;
                            valid <= 1'b1;
                        end
`else
                        if (sin) begin
                            data  <= shr;
                            valid <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
